// File: rtl/fc_pkg.sv
// Shared definitions for the FC result reader: FSM state encoding and width helpers.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fc_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width never drops below one bit, even for a single-neuron layer.
  function automatic int unsigned idx_width(input int unsigned n);
    return clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax over a stream of elements; ties keep the lowest index.
module argmax_tracker #(
  parameter int unsigned EW   = 16,
  parameter int unsigned IDXW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic signed [EW-1:0] elem,
  input  logic [IDXW-1:0]      k,
  output logic [IDXW-1:0]      idx
);

  logic signed [EW-1:0] r_max;
  logic [IDXW-1:0]      r_idx;
  logic                 w_better;

  assign w_better = (elem > r_max);

  // Beat 0 always seeds the tracker; later beats need a strictly larger value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (start) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (step) begin
      if ((k == '0) || w_better) begin
        r_max <= elem;
        r_idx <= k;
      end
    end
  end

  assign idx = r_idx;

endmodule

// File: rtl/fc_result_reader.sv
// Captures the FC result bus and streams it out one element per beat, reporting the argmax class.
module fc_result_reader
  import fc_pkg::*;
#(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned FILTERBATCH = 10,
  localparam int unsigned EW         = 2 * BITWIDTH,
  localparam int unsigned IDXW       = idx_width(FILTERBATCH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [EW*FILTERBATCH-1:0]   result,
  output logic                        busy,
  output logic [EW-1:0]               out_data,
  output logic [IDXW-1:0]             out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [IDXW-1:0]             class_idx,
  output logic                        class_valid
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FILTERBATCH - 1);

  fc_state_e       r_state;
  fc_state_e       w_state_nxt;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] w_cnt_nxt;
  logic [EW-1:0]   r_buf [FILTERBATCH];
  logic            r_busy;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_class_valid;
  logic            w_accept;
  logic            w_capture;
  logic [EW-1:0]   w_elem;

  assign w_accept = r_out_valid & out_ready;
  assign w_elem   = r_buf[r_cnt];

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end
      end
      STREAM: begin
        if (w_accept) begin
          if (r_out_last) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_class_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_out_valid   <= (w_state_nxt == STREAM);
      r_out_last    <= (w_state_nxt == STREAM) && (w_cnt_nxt == LAST_IDX);
      r_class_valid <= (w_state_nxt == DONE);
    end
  end

  // Capture buffer stays frozen outside the IDLE-to-STREAM transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FILTERBATCH); i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < int'(FILTERBATCH); i++) begin
        r_buf[i] <= result[i*EW +: EW];
      end
    end
  end

  argmax_tracker #(
    .EW   (EW),
    .IDXW (IDXW)
  ) u_argmax (
    .clk   (clk),
    .rst   (rst),
    .start (w_capture),
    .step  (w_accept),
    .elem  (w_elem),
    .k     (r_cnt),
    .idx   (class_idx)
  );

  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_index   = r_cnt;
  assign class_valid = r_class_valid;
  assign out_data    = r_out_valid ? w_elem : '0;

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed bench for fc_result_reader with a 4-neuron and a 1-neuron instance.
module tb_fc_result_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  class_idx;
  logic        class_valid;

  logic        load1;
  logic        ready1;
  logic [15:0] result1;
  logic        busy1;
  logic [15:0] data1;
  logic [0:0]  index1;
  logic        valid1;
  logic        last1;
  logic [0:0]  cidx1;
  logic        cvalid1;

  int n_checks = 0;
  int n_errors = 0;

  fc_result_reader #(.BITWIDTH(8), .FILTERBATCH(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .result      (result),
    .busy        (busy),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .class_idx   (class_idx),
    .class_valid (class_valid)
  );

  fc_result_reader #(.BITWIDTH(8), .FILTERBATCH(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .load        (load1),
    .result      (result1),
    .busy        (busy1),
    .out_data    (data1),
    .out_index   (index1),
    .out_valid   (valid1),
    .out_ready   (ready1),
    .out_last    (last1),
    .class_idx   (cidx1),
    .class_valid (cvalid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  // Streams one 4-element vector; bp toggles ready starting low, ign fires a stray load mid-stream.
  task automatic run4(input logic [63:0] bus, input int exp_cls, input bit bp, input bit ign);
    logic [63:0] cap;
    logic [15:0] e;
    int          beat;
    int          cyc;
    bit          rdy;
    cap       = bus;
    beat      = 0;
    cyc       = 0;
    result    = bus;
    load      = 1'b1;
    out_ready = bp ? 1'b0 : 1'b1;
    tick();
    load = 1'b0;
    while (beat < 4 && cyc < 20) begin
      e = cap[beat*16 +: 16];
      check("valid", out_valid, 1);
      check("data", out_data, e);
      check("index", out_index, beat);
      check("last", out_last, (beat == 3));
      check("busy", busy, 1);
      check("cls_valid_low", class_valid, 0);
      if (ign && cyc == 1) begin
        result = {4{16'd99}};
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      rdy       = bp ? (cyc % 2 == 1) : 1'b1;
      out_ready = rdy;
      tick();
      if (rdy) beat++;
      cyc++;
    end
    load = 1'b0;
    check("cycles", cyc, bp ? 8 : 4);
    check("done_cls_valid", class_valid, 1);
    check("done_cls_idx", class_idx, exp_cls);
    check("done_valid", out_valid, 0);
    check("done_busy", busy, 1);
    tick();
    check("idle_busy", busy, 0);
    check("idle_cls_valid", class_valid, 0);
    check("idle_cls_idx_held", class_idx, exp_cls);
    out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    load      = 1'b1;
    out_ready = 1'b1;
    result    = pack4(16'd1, 16'd2, 16'd3, 16'd4);
    load1     = 1'b1;
    ready1    = 1'b1;
    result1   = 16'h1234;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_cls_idx", class_idx, 0);
    check("rst_cls_valid", class_valid, 0);
    check("rst1_valid", valid1, 0);
    rst   = 1'b0;
    load  = 1'b0;
    load1 = 1'b0;
    tick();

    // Basic stream, then backpressure, then ignored reload.
    run4(pack4(16'd10, 16'(-3), 16'd25, 16'd7), 2, 1'b0, 1'b0);
    run4(pack4(16'd10, 16'(-3), 16'd25, 16'd7), 2, 1'b1, 1'b0);
    run4(pack4(16'(-5), 16'(-5), 16'(-9), 16'(-20)), 0, 1'b0, 1'b0);
    run4(pack4(16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000), 1, 1'b0, 1'b0);
    run4(pack4(16'd10, 16'(-3), 16'd25, 16'd7), 2, 1'b0, 1'b1);

    // Mid-stream reset after two accepted beats.
    result    = pack4(16'd1, 16'd5, 16'd9, 16'd2);
    load      = 1'b1;
    out_ready = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    check("mid_index", out_index, 2);
    check("mid_cls_idx", class_idx, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cls_idx", class_idx, 0);
    check("mrst_cls_valid", class_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_index", out_index, 0);
    tick();
    check("mrst_cls_valid2", class_valid, 0);
    check("mrst_busy2", busy, 0);
    run4(pack4(16'd10, 16'(-3), 16'd25, 16'd7), 2, 1'b0, 1'b0);

    // Single-neuron layer.
    result1 = 16'hFFFF;
    load1   = 1'b1;
    ready1  = 1'b0;
    tick();
    load1 = 1'b0;
    check("fb1_valid", valid1, 1);
    check("fb1_data", data1, 16'hFFFF);
    check("fb1_last", last1, 1);
    check("fb1_index", index1, 0);
    check("fb1_busy", busy1, 1);
    tick();
    check("fb1_hold_valid", valid1, 1);
    check("fb1_hold_data", data1, 16'hFFFF);
    ready1 = 1'b1;
    tick();
    check("fb1_cls_valid", cvalid1, 1);
    check("fb1_cls_idx", cidx1, 0);
    check("fb1_done_valid", valid1, 0);
    tick();
    check("fb1_idle_busy", busy1, 0);
    check("fb1_idle_cls_valid", cvalid1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
